// File: rtl/pipeline_defs.sv
// Shared definitions for the 16-bit pipeline: opcodes, register names, PCsrc and ALU encodings.
package pipeline_defs;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_ADDI = 4'd1;
  localparam logic [3:0] OP_LW   = 4'd2;
  localparam logic [3:0] OP_SW   = 4'd3;
  localparam logic [3:0] OP_BEQ  = 4'd4;
  localparam logic [3:0] OP_BNE  = 4'd5;
  localparam logic [3:0] OP_JMP  = 4'd6;
  localparam logic [3:0] OP_CALL = 4'd7;
  localparam logic [3:0] OP_RET  = 4'd8;

  localparam logic [2:0] R0 = 3'd0;
  localparam logic [2:0] R1 = 3'd1;
  localparam logic [2:0] R2 = 3'd2;
  localparam logic [2:0] R3 = 3'd3;
  localparam logic [2:0] R4 = 3'd4;
  localparam logic [2:0] R5 = 3'd5;
  localparam logic [2:0] R6 = 3'd6;
  localparam logic [2:0] R7 = 3'd7;

  localparam logic [1:0] PCSRC_SEQ    = 2'b00;
  localparam logic [1:0] PCSRC_JUMP   = 2'b01;
  localparam logic [1:0] PCSRC_BRANCH = 2'b10;
  localparam logic [1:0] PCSRC_RET    = 2'b11;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_SLL = 3'd5;
  localparam logic [2:0] ALU_SRL = 3'd6;
  localparam logic [2:0] ALU_SLT = 3'd7;

  localparam logic [15:0] NOP_INSTR = 16'h0000;

  function automatic logic [15:0] sext6(input logic [5:0] imm);
    return {{10{imm[5]}}, imm};
  endfunction

endpackage

// File: rtl/return_stack.sv
// Circular return-address stack: push overwrites the oldest entry when full, pop on empty is ignored.
// Updates on the clock edge; top/empty are combinational from current state, no backpressure.
module return_stack #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic [15:0] push_addr,
  output logic [15:0] top,
  output logic        empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [15:0]   entries [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;

  // wr_ptr wraps naturally because DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (push) begin
      wr_ptr <= wr_ptr + 1'b1;
      if (count != CW'(DEPTH))
        count <= count + 1'b1;
    end else if (pop && (count != '0)) begin
      wr_ptr <= wr_ptr - 1'b1;
      count  <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      entries[wr_ptr] <= push_addr;
  end

  assign top   = entries[wr_ptr - 1'b1];
  assign empty = (count == '0);

endmodule

// File: rtl/id_stage.sv
// Decode stage: IF/ID register, decode, hazard detection, branch/jump/return resolution, ID/EX register.
// Redirects fetch in the same cycle; stall holds fetch and IF/ID and injects a bubble into EX.
module id_stage #(
  parameter int          RAS_DEPTH = 4,
  parameter logic [15:0] NOP_INSTR = pipeline_defs::NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instruction,
  input  logic [15:0] NPC,
  output logic [2:0]  rf_raddr1,
  output logic [2:0]  rf_raddr2,
  input  logic [15:0] rf_rdata1,
  input  logic [15:0] rf_rdata2,
  input  logic [2:0]  ex_rd,
  input  logic        ex_reg_write,
  input  logic        ex_mem_read,
  input  logic [2:0]  mem_rd,
  input  logic        mem_reg_write,
  input  logic        mem_mem_read,
  input  logic [15:0] mem_alu_result,
  input  logic [2:0]  wb_rd,
  input  logic        wb_reg_write,
  input  logic [15:0] wb_data,
  output logic        stall,
  output logic        kill,
  output logic [1:0]  PCsrc,
  output logic [15:0] J_TypeImmediate,
  output logic [15:0] I_TypeImmediate,
  output logic [15:0] ReturnAddress,
  output logic        idex_valid,
  output logic        idex_reg_write,
  output logic        idex_mem_read,
  output logic        idex_mem_write,
  output logic        idex_alu_src,
  output logic [2:0]  idex_alu_op,
  output logic [2:0]  idex_rd,
  output logic [15:0] idex_a,
  output logic [15:0] idex_b,
  output logic [15:0] idex_imm
);

  import pipeline_defs::*;

  logic [15:0] ifid_instr;
  logic [15:0] ifid_npc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ifid_instr <= NOP_INSTR;
      ifid_npc   <= '0;
    end else if (!stall) begin
      ifid_instr <= instruction;
      ifid_npc   <= NPC;
    end
  end

  logic [3:0]  opcode;
  logic [2:0]  f_rd, f_rs1, f_rs2, f_func;
  logic [15:0] imm_sext;

  assign opcode   = ifid_instr[15:12];
  assign f_rd     = ifid_instr[11:9];
  assign f_rs1    = ifid_instr[8:6];
  assign f_rs2    = ifid_instr[5:3];
  assign f_func   = ifid_instr[2:0];
  assign imm_sext = sext6(ifid_instr[5:0]);

  logic       dec_bubble, dec_reg_write, dec_mem_read, dec_mem_write, dec_alu_src;
  logic [2:0] dec_alu_op, dec_rd;
  logic       uses_rs1, uses_rs2;
  logic       is_branch, is_bne, is_jump, is_call, is_ret;

  always_comb begin
    dec_bubble    = 1'b1;
    dec_reg_write = 1'b0;
    dec_mem_read  = 1'b0;
    dec_mem_write = 1'b0;
    dec_alu_src   = 1'b0;
    dec_alu_op    = ALU_ADD;
    dec_rd        = R0;
    uses_rs1      = 1'b0;
    uses_rs2      = 1'b0;
    is_branch     = 1'b0;
    is_bne        = 1'b0;
    is_jump       = 1'b0;
    is_call       = 1'b0;
    is_ret        = 1'b0;
    case (opcode)
      OP_ADD: begin
        dec_bubble    = 1'b0;
        dec_reg_write = 1'b1;
        dec_alu_op    = f_func;
        dec_rd        = f_rd;
        uses_rs1      = 1'b1;
        uses_rs2      = 1'b1;
      end
      OP_ADDI: begin
        dec_bubble    = 1'b0;
        dec_reg_write = 1'b1;
        dec_alu_src   = 1'b1;
        dec_rd        = f_rd;
        uses_rs1      = 1'b1;
      end
      OP_LW: begin
        dec_bubble    = 1'b0;
        dec_reg_write = 1'b1;
        dec_mem_read  = 1'b1;
        dec_alu_src   = 1'b1;
        dec_rd        = f_rd;
        uses_rs1      = 1'b1;
      end
      OP_SW: begin
        dec_bubble    = 1'b0;
        dec_mem_write = 1'b1;
        dec_alu_src   = 1'b1;
        uses_rs1      = 1'b1;
        uses_rs2      = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        is_branch = 1'b1;
        is_bne    = (opcode == OP_BNE);
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b1;
      end
      OP_JMP:  is_jump = 1'b1;
      OP_CALL: is_call = 1'b1;
      OP_RET:  is_ret  = 1'b1;
      default: dec_bubble = 1'b1;
    endcase
    if (ifid_instr == NOP_INSTR)
      dec_bubble = 1'b1;
  end

  // R-type reads its second source from [5:3]; stores and branches use [11:9]
  assign rf_raddr1 = f_rs1;
  assign rf_raddr2 = (opcode == OP_ADD) ? f_rs2 : f_rd;

  function automatic logic branch_src_hazard(input logic [2:0] src);
    return (src != R0) &&
           ((ex_reg_write && (ex_rd == src)) ||
            (mem_reg_write && mem_mem_read && (mem_rd == src)));
  endfunction

  function automatic logic [15:0] branch_operand(input logic [2:0] src, input logic [15:0] rf_val);
    if (src == R0)
      return 16'h0000;
    else if (mem_reg_write && (mem_rd == src))
      return mem_alu_result;
    else if (wb_reg_write && (wb_rd == src))
      return wb_data;
    else
      return rf_val;
  endfunction

  logic        load_use, branch_hazard, taken;
  logic [15:0] br_a, br_b;

  assign load_use = ex_mem_read && ex_reg_write && (ex_rd != R0) &&
                    ((uses_rs1 && (ex_rd == rf_raddr1)) ||
                     (uses_rs2 && (ex_rd == rf_raddr2)));
  assign branch_hazard = is_branch &&
                         (branch_src_hazard(rf_raddr1) || branch_src_hazard(rf_raddr2));
  assign stall = load_use || branch_hazard;

  assign br_a  = branch_operand(rf_raddr1, rf_rdata1);
  assign br_b  = branch_operand(rf_raddr2, rf_rdata2);
  assign taken = is_branch && (is_bne ? (br_a != br_b) : (br_a == br_b));

  // A stalled instruction never redirects; it retries once operands are ready
  always_comb begin
    PCsrc = PCSRC_SEQ;
    kill  = 1'b0;
    if (!stall) begin
      if (taken) begin
        PCsrc = PCSRC_BRANCH;
        kill  = 1'b1;
      end else if (is_jump || is_call) begin
        PCsrc = PCSRC_JUMP;
        kill  = 1'b1;
      end else if (is_ret) begin
        PCsrc = PCSRC_RET;
        kill  = 1'b1;
      end
    end
  end

  assign I_TypeImmediate = ifid_npc - 16'd1 + imm_sext;
  assign J_TypeImmediate = {ifid_npc[15:12], ifid_instr[11:0]};

  logic [15:0] ras_top;
  logic        ras_empty;

  return_stack #(.DEPTH(RAS_DEPTH)) u_ras (
    .clk       (clk),
    .rst       (reset),
    .push      (!stall && is_call),
    .pop       (!stall && is_ret),
    .push_addr (ifid_npc),
    .top       (ras_top),
    .empty     (ras_empty)
  );

  assign ReturnAddress = ras_empty ? 16'h0000 : ras_top;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idex_valid     <= 1'b0;
      idex_reg_write <= 1'b0;
      idex_mem_read  <= 1'b0;
      idex_mem_write <= 1'b0;
      idex_alu_src   <= 1'b0;
      idex_alu_op    <= '0;
      idex_rd        <= '0;
      idex_a         <= '0;
      idex_b         <= '0;
      idex_imm       <= '0;
    end else if (stall || dec_bubble) begin
      idex_valid     <= 1'b0;
      idex_reg_write <= 1'b0;
      idex_mem_read  <= 1'b0;
      idex_mem_write <= 1'b0;
      idex_alu_src   <= 1'b0;
      idex_alu_op    <= '0;
      idex_rd        <= '0;
      idex_a         <= '0;
      idex_b         <= '0;
      idex_imm       <= '0;
    end else begin
      idex_valid     <= 1'b1;
      idex_reg_write <= dec_reg_write;
      idex_mem_read  <= dec_mem_read;
      idex_mem_write <= dec_mem_write;
      idex_alu_src   <= dec_alu_src;
      idex_alu_op    <= dec_alu_op;
      idex_rd        <= dec_rd;
      idex_a         <= rf_rdata1;
      idex_b         <= rf_rdata2;
      idex_imm       <= imm_sext;
    end
  end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Instruction-decode stage, directly downstream of the fetch stage.
- Holds the IF/ID pipeline register and decodes the 16-bit instruction.
- Drives register-file read addresses, detects load-use and branch hazards, and resolves branches, jumps, calls and returns in ID.
- Feeds the fetch stage its stall, kill, PCsrc and target addresses; feeds execute through a registered ID/EX boundary.

Parameters:
RAS_DEPTH, 4, return-address-stack entries (power of two, 2..16)
NOP_INSTR, 16'h0000, encoding treated as bubble (ADD R0,R0,R0)

Ports:
clk  in  1  stage clock, rising edge
reset  in  1  asynchronous, active-high
instruction  in  16  from fetch (already NOP-substituted on kill)
NPC  in  16  fetch PC+1 of that instruction
rf_raddr1, rf_raddr2  out  3  register-file read addresses (comb)
rf_rdata1, rf_rdata2  in  16  register-file read data (comb)
ex_rd  in  3  EX destination; ex_reg_write, ex_mem_read  in  1
mem_rd  in  3  MEM destination; mem_reg_write, mem_mem_read  in  1; mem_alu_result  in  16
wb_rd  in  3  WB destination; wb_reg_write  in  1; wb_data  in  16
stall  out  1  hold fetch PC and IF/ID (comb)
kill  out  1  squash instruction being fetched (comb)
PCsrc  out  2  00 seq, 01 jump/call, 10 branch, 11 return
J_TypeImmediate, I_TypeImmediate, ReturnAddress  out  16  redirect targets
idex_valid, idex_reg_write, idex_mem_read, idex_mem_write, idex_alu_src  out  1  registered controls
idex_alu_op  out  3; idex_rd  out  3; idex_a, idex_b, idex_imm  out  16  registered

Behaviour:
- Formats: [15:12] op; R: rd[11:9] rs1[8:6] rs2[5:3] func[2:0]; I: rd/rs2[11:9] rs1[8:6] imm6[5:0] signed; J: off12[11:0].
- Opcodes:
  - 0 ADD/R (alu_op=func)
  - 1 ADDI, 2 LW, 3 SW
  - 4 BEQ, 5 BNE (compare rs1 vs reg[11:9])
  - 6 JMP, 7 CALL, 8 RET
  - 9-15 decode as bubble
- IF/ID register:
  - Captures instruction/NPC every rising edge with stall=0; holds when stall=1.
  - Reset loads NOP_INSTR and NPC=0.
- Immediates:
  - idex_imm = sext(imm6).
  - I_TypeImmediate = NPC-1+sext(imm6), modulo 2^16.
  - J_TypeImmediate = {NPC[15:12], off12}.
  - ReturnAddress = RAS top, or 16'h0000 when empty.
- Load-use stall: ex_mem_read & ex_reg_write & ex_rd!=0 & ex_rd matches a source the instruction reads → stall=1.
- Branch/RET operand hazards (BEQ/BNE sources only):
  - EX writer of a source → stall.
  - MEM writer with mem_mem_read → stall.
  - MEM writer without mem_mem_read → forward mem_alu_result.
  - Otherwise WB writer → forward wb_data.
  - Otherwise rf_rdata.
  - R0 never hazards and always reads 0.
- Redirect (only when stall=0), same cycle (0 latency):
  - Taken branch → PCsrc=10, kill=1.
  - JMP, CALL → PCsrc=01, kill=1.
  - RET → PCsrc=11, kill=1.
  - Otherwise PCsrc=00, kill=0.
- RAS, updated at the clock edge of the resolving cycle:
  - CALL pushes NPC. Push when full overwrites the oldest entry (circular); count saturates at RAS_DEPTH.
  - RET pops. Pop when empty: no change, target 0.
- ID/EX register:
  - Updates every edge.
  - When stall=1 or the decode is a bubble, loads idex_valid=0 with all write/mem enables 0.
  - Branches, JMP, RET and CALL enter EX as bubbles.
- Reset (asynchronous, any cycle, including mid-stall):
  - All idex_* = 0.
  - RAS empty.
  - IF/ID = NOP.
  - Combinational outputs then settle to stall=0, kill=0, PCsrc=00.
- Stall and taken redirect in the same cycle: stall wins; no kill, no RAS change; redirect happens on the retry cycle.

Decomposition:
- Shared package pipeline_defs:
  - opcode constants (ADD…RET), register constants R0–R7
  - PCsrc encodings
  - ALU op codes
  - NOP_INSTR
- Sub-module return_stack: RAS_DEPTH entries, push/pop/top/empty, circular pointer plus saturating count.
- Hazard and forwarding logic stays inline.

Test Plan:
1. ADD R1,R2,R3 at NPC=5, no hazards → next edge idex_valid=1, idex_alu_op=func, idex_rd=1, stall=0, kill=0, PCsrc=00.
2. LW R2 in EX (ex_mem_read=1, ex_rd=2), ID holds ADD R1,R2,R3 → stall=1 for one cycle, idex_valid=0 bubble, IF/ID unchanged; next cycle stall=0.
3. BEQ R1,R1, imm6=-3 at NPC=10 → PCsrc=10, kill=1, I_TypeImmediate=6; with imm6=+5 and operands unequal → PCsrc=00, kill=0.
4. BNE with mem_rd=4, mem_alu_result=7, rf_rdata=0 and other operand 7 → not taken (forwarded); same case with mem_mem_read=1 → stall=1, kill=0.
5. CALL off12=0x040 at NPC=0x1003 → PCsrc=01, J_TypeImmediate=0x1040, push 0x1003; later RET → PCsrc=11, ReturnAddress=0x1003, RAS empty afterwards.
6. Five CALLs with RAS_DEPTH=4, then five RETs → first four return the newest four addresses in LIFO order, fifth returns 0; reset asserted mid-stall → idex_* = 0 immediately, stall=0.
